sevenseg_scan_decoder: RTL
==========================

// Module: sevenseg_scan_decoder
// PURPOSE
//  Receive-side counterpart of the multiplexed 4-digit seven-segment drive (Anode/Cathode).
//  Samples the scanned anode/cathode lines and settles each digit's segment pattern.
//  Decodes each pattern back to BCD and presents the displayed MM:SS value.
//  Used as an on-board display monitor and as the self-check for the clock display path.
// PARAMETERS
//  STABLE_SAMPLES   4      consecutive identical samples needed to accept a pattern (>=2)
//  TIMEOUT_SAMPLES  1024   samples without an accept for a digit before its valid bit drops
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high; clears all state
//  sample_en    in   1  one-cycle sample strobe (e.g. 50 Hz-scan-rate x4 tick)
//  anode        in   4  active-low digit enables; [3]=min_ten [2]=min_one [1]=sec_ten [0]=sec_one
//  cathode      in   7  active-low segments {g,f,e,d,c,b,a}
//  min_ten      out  4  decoded BCD, tens of minutes
//  min_one      out  4  decoded BCD, units of minutes
//  sec_ten      out  4  decoded BCD, tens of seconds
//  sec_one      out  4  decoded BCD, units of seconds
//  digit_valid  out  4  per-digit valid, same bit order as anode
//  frame_done   out  1  one-cycle pulse when all four digits accepted since last pulse
//  err          out  1  one-cycle pulse on illegal accepted pattern
// BEHAVIOUR
//  - anode/cathode pass a 2-FF synchronizer; sampling uses synchronized values only.
//  - Pattern P = {anode,cathode} (11 b), compared with previous sample on each sample_en.
//  - FSM (advances only on sample_en):
//     SETTLE: P==prev -> cnt++; when cnt reaches STABLE_SAMPLES -> ACCEPT, go LOCKED.
//             P!=prev -> cnt=1, stay SETTLE.
//     LOCKED: P==prev -> stay, no re-accept; P!=prev -> cnt=1, go SETTLE.
//  - cnt is $clog2(STABLE_SAMPLES+1) bits, saturating; never wraps.
//  - ACCEPT is one cycle, registered; outputs update the cycle after the accepting sample_en.
//  - ACCEPT actions:
//     anode==4'b1111 (blank): no update, no err.
//     exactly one anode low, cathode legal: store BCD to that digit, set valid bit and seen bit.
//     exactly one anode low, cathode illegal: err pulse, clear that valid bit, keep BCD.
//     >1 anode low: err pulse, no digit or valid change.
//  - Legal cathode (hex, active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
//    All other codes are illegal.
//  - Timeout: per-digit counter ($clog2(TIMEOUT_SAMPLES+1) b), +1 per sample_en, cleared on
//    that digit's accept. At TIMEOUT_SAMPLES, the valid bit clears and the counter holds.
//    The BCD value is retained. Accept and timeout on the same digit in the same cycle:
//    accept wins.
//  - frame_done: seen_next = seen | accepted_bit. If seen_next==4'hF, pulse frame_done and
//    clear seen the same cycle.
//  - Reset values: all BCD outputs 0, digit_valid 0, frame_done 0, err 0, seen 0, state SETTLE,
//    cnt 0, prev 11'h7FF, sync FFs 11'h7FF, timeout counters 0.
//  - Reset asserted mid-settle clears progress immediately. After release, a full
//    STABLE_SAMPLES run is needed.
//  - sample_en held high: samples every clk; behaviour is otherwise identical.
// TESTING
//  1 Scan 12:34, each digit held 4 samples (anode 0111/cathode 79, 1011/24, 1101/30, 1110/19)
//    -> min_ten=1 min_one=2 sec_ten=3 sec_one=4, valid=F, one frame_done after sec_one accept.
//  2 Glitch: anode 1110 cathode 40 for 3 samples then change
//    -> sec_one unchanged, no valid change, no err.
//  3 Illegal: anode 1110 cathode 7F for 4 samples -> one err pulse, digit_valid[0]=0,
//    sec_one keeps prior value.
//  4 Multi-anode: anode 1100 cathode 79 for 4 samples -> one err pulse, outputs unchanged.
//  5 Blink: omit min_ten for 1024 samples while scanning others -> digit_valid[3]=0,
//    min_ten retained; resume -> valid[3]=1 after 4 samples.
//  6 Reset pulse after 2 of 4 stable samples -> all outputs 0 immediately;
//    accept only after 4 fresh samples.

Source files
------------

// File: rtl/sevenseg_scan_decoder_if.sv
// Scanned seven-segment monitor bus: scan inputs from the display drive and decoded
// MM:SS results back out.
interface sevenseg_scan_decoder_if;
    logic       sample_en;
    logic [3:0] anode;
    logic [6:0] cathode;
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
    logic [3:0] digit_valid;
    logic       frame_done;
    logic       err;

    modport master (
        output sample_en, anode, cathode,
        input  min_ten, min_one, sec_ten, sec_one, digit_valid, frame_done, err
    );

    modport slave (
        input  sample_en, anode, cathode,
        output min_ten, min_one, sec_ten, sec_one, digit_valid, frame_done, err
    );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Watches a multiplexed 4-digit seven-segment drive, settles each scanned pattern and
// decodes it back to BCD with per-digit valid, frame and error reporting.
module sevenseg_scan_decoder #(
    parameter int unsigned STABLE_SAMPLES  = 4,
    parameter int unsigned TIMEOUT_SAMPLES = 1024
) (
    input logic                    clk,
    input logic                    reset,
    sevenseg_scan_decoder_if.slave bus
);
    localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [CW-1:0] SMAX = CW'(STABLE_SAMPLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_SAMPLES);

    typedef enum logic {StSettle, StLocked} state_t;

    state_t      state;
    logic [10:0] sync1, sync2, prev, acc_pat;
    logic [CW-1:0] cnt, cnt_inc;
    logic        accept;
    logic [3:0]  digit [4];
    logic [TW-1:0] tcnt [4];
    logic [TW-1:0] tcnt_d [4];
    logic [3:0]  valid, valid_d, seen, seen_next;
    logic [3:0]  sel, acc_bit, bad_bit, hit;
    logic        single, legal, err_next, frame_done, err;
    logic [3:0]  bcd;

    // Returns {legal, bcd} for an active-low {g..a} pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] c);
        case (c)
            7'h40:   decode_seg = {1'b1, 4'd0};
            7'h79:   decode_seg = {1'b1, 4'd1};
            7'h24:   decode_seg = {1'b1, 4'd2};
            7'h30:   decode_seg = {1'b1, 4'd3};
            7'h19:   decode_seg = {1'b1, 4'd4};
            7'h12:   decode_seg = {1'b1, 4'd5};
            7'h02:   decode_seg = {1'b1, 4'd6};
            7'h78:   decode_seg = {1'b1, 4'd7};
            7'h00:   decode_seg = {1'b1, 4'd8};
            7'h10:   decode_seg = {1'b1, 4'd9};
            default: decode_seg = 5'd0;
        endcase
    endfunction

    always_comb begin
        cnt_inc = (cnt == SMAX) ? cnt : cnt + CW'(1);
        {legal, bcd} = decode_seg(acc_pat[6:0]);
        sel     = ~acc_pat[10:7];
        single  = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
        hit     = (accept && single) ? sel : 4'd0;
        acc_bit = legal ? hit : 4'd0;
        bad_bit = legal ? 4'd0 : hit;
        // A blank frame (no anode low) is neither a digit nor an error.
        err_next  = accept && (sel != 4'd0) && (!single || !legal);
        seen_next = seen | acc_bit;
        for (int i = 0; i < 4; i++) begin
            tcnt_d[i] = tcnt[i];
            if (hit[i]) begin
                tcnt_d[i] = '0;
            end else if (bus.sample_en && tcnt[i] != TMAX) begin
                tcnt_d[i] = tcnt[i] + TW'(1);
            end
            valid_d[i] = valid[i];
            if (acc_bit[i]) begin
                valid_d[i] = 1'b1;
            end else if (bad_bit[i] || tcnt_d[i] == TMAX) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 11'h7FF;
            sync2      <= 11'h7FF;
            prev       <= 11'h7FF;
            acc_pat    <= 11'h7FF;
            state      <= StSettle;
            cnt        <= '0;
            accept     <= 1'b0;
            valid      <= 4'd0;
            seen       <= 4'd0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit[i] <= 4'd0;
                tcnt[i]  <= '0;
            end
        end else begin
            sync1  <= {bus.anode, bus.cathode};
            sync2  <= sync1;
            accept <= 1'b0;
            if (bus.sample_en) begin
                prev <= sync2;
                if (sync2 != prev) begin
                    cnt   <= CW'(1);
                    state <= StSettle;
                end else if (state == StSettle) begin
                    cnt <= cnt_inc;
                    if (cnt_inc == SMAX) begin
                        accept  <= 1'b1;
                        acc_pat <= sync2;
                        state   <= StLocked;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (acc_bit[i]) digit[i] <= bcd;
                tcnt[i] <= tcnt_d[i];
            end
            valid      <= valid_d;
            err        <= err_next;
            frame_done <= (seen_next == 4'hF);
            seen       <= (seen_next == 4'hF) ? 4'd0 : seen_next;
        end
    end

    assign bus.min_ten     = digit[3];
    assign bus.min_one     = digit[2];
    assign bus.sec_ten     = digit[1];
    assign bus.sec_one     = digit[0];
    assign bus.digit_valid = valid;
    assign bus.frame_done  = frame_done;
    assign bus.err         = err;
endmodule
